// File: rtl/modport_fifo_pkg.sv
// rtl/modport_fifo_pkg.sv - shared defaults and types for the 128-bit synchronous FIFO
package modport_fifo_pkg;

    localparam int DATA_W_DEF   = 128;
    localparam int DEPTH_DEF    = 16;
    localparam int AF_LEVEL_DEF = 12;
    localparam int AE_LEVEL_DEF = 4;

    localparam int PTR_W_DEF = $clog2(DEPTH_DEF);
    localparam int CNT_W_DEF = PTR_W_DEF + 1;

    typedef logic [PTR_W_DEF-1:0] ptr_t;
    typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/modport_fifo_ram.sv
// rtl/modport_fifo_ram.sv - DEPTH x DATA_W storage, one write port, one registered read port
module fifo_ram
    import modport_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array is left unreset so it can map onto plain RAM macros.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/modport_fifo.sv
// rtl/modport_fifo.sv - single-clock FIFO with registered read data and registered status flags
module modport_fifo
    import modport_fifo_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AF_LEVEL = AF_LEVEL_DEF,
    parameter int AE_LEVEL = AE_LEVEL_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wren,
    input  logic              i_rden,
    input  logic [DATA_W-1:0] i_wrdata,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_alm_full,
    output logic              o_alm_empty,
    output logic [DATA_W-1:0] o_rddata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             wr_acc;
    logic             rd_acc;

    // Acceptance uses the registered flags, so a full FIFO drops a write even when a read
    // frees a slot the same cycle, and an empty FIFO never bypasses write data to the reader.
    assign wr_acc = i_wren && !o_full;
    assign rd_acc = i_rden && !o_empty;

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_full      <= 1'b0;
            o_empty     <= 1'b1;
            o_alm_full  <= 1'b0;
            o_alm_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count       <= count_next;
            o_full      <= (count_next == CNT_W'(DEPTH));
            o_empty     <= (count_next == '0);
            o_alm_full  <= (count_next >= CNT_W'(AF_LEVEL));
            o_alm_empty <= (count_next <= CNT_W'(AE_LEVEL));
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (i_wrdata),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (o_rddata)
    );

endmodule

// File: tb/tb_modport_fifo.sv
// tb/tb_modport_fifo.sv - directed self-checking bench for modport_fifo
`timescale 1ns/1ps
module tb_modport_fifo;

    logic         clk;
    logic         reset;
    logic         i_wren;
    logic         i_rden;
    logic [127:0] i_wrdata;
    logic         o_full;
    logic         o_empty;
    logic         o_alm_full;
    logic         o_alm_empty;
    logic [127:0] o_rddata;

    int n_checks;
    int n_fail;

    modport_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .i_wren      (i_wren),
        .i_rden      (i_rden),
        .i_wrdata    (i_wrdata),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_alm_full  (o_alm_full),
        .o_alm_empty (o_alm_empty),
        .o_rddata    (o_rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic wr, input logic rd, input logic [127:0] d);
        i_wren   = wr;
        i_rden   = rd;
        i_wrdata = d;
        @(posedge clk);
        #1;
        i_wren   = 1'b0;
        i_rden   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({o_empty, o_alm_empty, o_full, o_alm_full} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_flags: got e/ae/f/af=%b want 1100",
                     {o_empty, o_alm_empty, o_full, o_alm_full});
        end
        n_checks++;
        if (o_rddata !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_rddata: got %h want 0", o_rddata);
        end
        reset = 1'b0;
        step(1'b0, 1'b0, 128'h0);
        n_checks++;
        if ({o_empty, o_alm_empty, o_full, o_alm_full} !== 4'b1100) begin
            n_fail++;
            $display("FAIL post_reset_flags: got %b want 1100",
                     {o_empty, o_alm_empty, o_full, o_alm_full});
        end
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b0, 128'(k - 1));
            n_checks++;
            if (o_alm_empty !== (k <= 4) || o_alm_full !== (k >= 12) ||
                o_full !== (k == 16) || o_empty !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_flags[%0d]: got e/ae/f/af=%b%b%b%b want 0%b%b%b", k,
                         o_empty, o_alm_empty, o_full, o_alm_full,
                         (k <= 4), (k == 16), (k >= 12));
            end
        end
        step(1'b1, 1'b0, 128'hDEAD);
        n_checks++;
        if (o_full !== 1'b1 || o_alm_full !== 1'b1 || o_rddata !== 128'h0) begin
            n_fail++;
            $display("FAIL overflow: got full=%b af=%b rd=%h want 1 1 0",
                     o_full, o_alm_full, o_rddata);
        end
    endtask

    task automatic test_drain();
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 1'b1, 128'h0);
            n_checks++;
            if (o_rddata !== 128'(k - 1) || o_empty !== (k == 16) || o_full !== 1'b0 ||
                o_alm_empty !== (k >= 12) || o_alm_full !== (k <= 4)) begin
                n_fail++;
                $display("FAIL drain[%0d]: got rd=%h e/ae/f/af=%b%b%b%b want rd=%h", k,
                         o_rddata, o_empty, o_alm_empty, o_full, o_alm_full, 128'(k - 1));
            end
        end
        step(1'b0, 1'b1, 128'h0);
        n_checks++;
        if (o_rddata !== 128'd15 || o_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow: got rd=%h empty=%b want 15 1", o_rddata, o_empty);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 128'(100 + i));
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 128'h0);
            n_checks++;
            if (o_rddata !== 128'(100 + i)) begin
                n_fail++;
                $display("FAIL wrap_a[%0d]: got %h want %h", i, o_rddata, 128'(100 + i));
            end
        end
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 128'(200 + i));
        n_checks++;
        if (o_full !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_full: got %b want 1", o_full);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 128'h0);
            n_checks++;
            if (o_rddata !== 128'(200 + i)) begin
                n_fail++;
                $display("FAIL wrap_b[%0d]: got %h want %h", i, o_rddata, 128'(200 + i));
            end
        end
        n_checks++;
        if (o_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_empty: got %b want 1", o_empty);
        end
    endtask

    task automatic test_concurrent();
        logic [127:0] exp_d;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 128'(300 + i));
        for (int j = 0; j < 20; j++) begin
            step(1'b1, 1'b1, 128'(400 + j));
            exp_d = (j < 8) ? 128'(300 + j) : 128'(400 + j - 8);
            n_checks++;
            if (o_rddata !== exp_d ||
                {o_empty, o_alm_empty, o_full, o_alm_full} !== 4'b0000) begin
                n_fail++;
                $display("FAIL concurrent[%0d]: got rd=%h flags=%b want rd=%h flags=0000", j,
                         o_rddata, {o_empty, o_alm_empty, o_full, o_alm_full}, exp_d);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 128'h0);
            n_checks++;
            if (o_rddata !== 128'(412 + i)) begin
                n_fail++;
                $display("FAIL conc_drain[%0d]: got %h want %h", i, o_rddata, 128'(412 + i));
            end
        end
        n_checks++;
        if (o_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL conc_empty: got %b want 1", o_empty);
        end
    endtask

    task automatic test_midop_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 128'(500 + i));
        step(1'b0, 1'b1, 128'h0);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({o_empty, o_alm_empty, o_full, o_alm_full} !== 4'b1100 || o_rddata !== 128'h0) begin
            n_fail++;
            $display("FAIL async_reset: got flags=%b rd=%h want 1100 0",
                     {o_empty, o_alm_empty, o_full, o_alm_full}, o_rddata);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, 128'h0);
        n_checks++;
        if (o_rddata !== 128'h0 || o_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_read_empty: got rd=%h empty=%b want 0 1", o_rddata, o_empty);
        end
        step(1'b1, 1'b0, 128'hABC);
        n_checks++;
        if (o_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_write: got empty=%b want 0", o_empty);
        end
        step(1'b0, 1'b1, 128'h0);
        n_checks++;
        if (o_rddata !== 128'hABC || o_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_readback: got rd=%h empty=%b want abc 1", o_rddata, o_empty);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        i_wren   = 1'b0;
        i_rden   = 1'b0;
        i_wrdata = '0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_concurrent();
        test_midop_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
